// File: rtl/mult_pkg.sv
// Shared constants and sizing helpers for the pipelined array multiplier.
package mult_pkg;

  // Supported operand widths.
  localparam int WIDTH_MIN = 2;
  localparam int WIDTH_MAX = 32;

  // One register stage per partial-product row after the first.
  function automatic int stages_of(input int width);
    return width - 1;
  endfunction

  // Exact product width; the product can never overflow this.
  function automatic int prod_width_of(input int width);
    return 2 * width;
  endfunction

endpackage

// File: rtl/rca_n.sv
// N-bit ripple-carry adder built from the half/full adder cells.

module Halfadder (
  input  logic a,
  input  logic b,
  output logic s,
  output logic co
);
  assign s  = a ^ b;
  assign co = a & b;
endmodule

module Fulladder (
  input  logic a,
  input  logic b,
  input  logic ci,
  output logic s,
  output logic co
);
  assign s  = a ^ b ^ ci;
  assign co = (a & b) | (ci & (a ^ b));
endmodule

module rca_n #(
  parameter int N = 4
) (
  input  logic [N-1:0] a,
  input  logic [N-1:0] b,
  output logic [N-1:0] sum,
  output logic         cout
);
  logic [N:1] c;

  Halfadder u_ha (.a(a[0]), .b(b[0]), .s(sum[0]), .co(c[1]));

  for (genvar i = 1; i < N; i++) begin : g_fa
    Fulladder u_fa (.a(a[i]), .b(b[i]), .ci(c[i]), .s(sum[i]), .co(c[i+1]));
  end

  assign cout = c[N];
endmodule

// File: rtl/pipelined_multiplier_n.sv
// Fully pipelined unsigned WIDTH x WIDTH array multiplier with valid/ready
// flow control. One ripple-carry row per stage; the whole pipe advances or
// stalls together.
module pipelined_multiplier_n
  import mult_pkg::*;
#(
  parameter int WIDTH = 4
) (
  input  logic               clk,
  input  logic               rst,
  input  logic [WIDTH-1:0]   x,
  input  logic [WIDTH-1:0]   y,
  input  logic               in_valid,
  output logic               in_ready,
  output logic [2*WIDTH-1:0] out,
  output logic               out_valid,
  input  logic               out_ready
);
  localparam int STAGES = stages_of(WIDTH);
  localparam int P_W    = prod_width_of(WIDTH);

  // Stage registers. y_q is kept shifted so bit 0 is always the next
  // multiplier bit to consume; bits already consumed fall off the bottom.
  logic [P_W-1:0]   acc_q [1:STAGES];
  logic [WIDTH-1:0] x_q   [1:STAGES];
  logic [WIDTH-1:0] y_q   [1:STAGES];
  logic             vld_q [1:STAGES];

  // What each stage loads from: index 0 is the input port, index s the
  // register of stage s.
  logic [P_W-1:0]   src_acc [0:STAGES-1];
  logic [WIDTH-1:0] src_x   [0:STAGES-1];
  logic [WIDTH-1:0] src_y   [0:STAGES-1];
  logic             src_vld [0:STAGES-1];

  logic [WIDTH-1:0] rca_a    [1:STAGES];
  logic [WIDTH-1:0] pp       [1:STAGES];
  logic [WIDTH-1:0] rca_sum  [1:STAGES];
  logic             rca_cout [1:STAGES];
  logic [P_W-1:0]   acc_d    [1:STAGES];

  logic adv;

  assign out_valid = vld_q[STAGES];
  assign out       = acc_q[STAGES];
  assign adv       = !out_valid || out_ready;
  assign in_ready  = adv;

  // Predecessor selection; the input side seeds the running sum with PP0.
  always_comb begin
    src_acc[0] = {{WIDTH{1'b0}}, x & {WIDTH{y[0]}}};
    src_x[0]   = x;
    src_y[0]   = y >> 1;
    src_vld[0] = in_valid;
    for (int s = 1; s < STAGES; s++) begin
      src_acc[s] = acc_q[s];
      src_x[s]   = x_q[s];
      src_y[s]   = y_q[s];
      src_vld[s] = vld_q[s];
    end
  end

  for (genvar s = 1; s <= STAGES; s++) begin : g_stage
    // Bits below s are final and pass through; the upper WIDTH bits of the
    // running sum get PPs added and land at [s+WIDTH:s].
    localparam logic [P_W-1:0] LOW_MASK = (P_W'(1) << s) - P_W'(1);

    assign rca_a[s] = src_acc[s-1][s+WIDTH-1:s];
    assign pp[s]    = src_x[s-1] & {WIDTH{src_y[s-1][0]}};

    rca_n #(.N(WIDTH)) u_rca (
      .a    (rca_a[s]),
      .b    (pp[s]),
      .sum  (rca_sum[s]),
      .cout (rca_cout[s])
    );

    assign acc_d[s] = (src_acc[s-1] & LOW_MASK)
                    | (P_W'({rca_cout[s], rca_sum[s]}) << s);
  end

  // All stages load together on adv; reset clears valids and the product.
  always_ff @(posedge clk) begin
    for (int s = 1; s <= STAGES; s++) begin
      if (rst) begin
        vld_q[s] <= 1'b0;
        acc_q[s] <= '0;
      end else if (adv) begin
        vld_q[s] <= src_vld[s-1];
        acc_q[s] <= acc_d[s];
        x_q[s]   <= src_x[s-1];
        y_q[s]   <= src_y[s-1] >> 1;
      end
    end
  end

endmodule

// File: tb/tb_pipelined_multiplier_n.sv
// Directed and table-driven bench for pipelined_multiplier_n at widths 2, 4,
// 8 and 16. A selector routes the shared stimulus to one instance at a time.
module tb_pipelined_multiplier_n;

  typedef struct {
    logic [15:0] x;
    logic [15:0] y;
    logic [31:0] exp;
  } vec_t;

  vec_t vecs[$];

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic [15:0] dx = '0;
  logic [15:0] dy = '0;
  logic        dv = 1'b0;
  logic        dr = 1'b1;
  int          sel = 4;
  int          n_pass = 0;
  int          n_total = 0;

  logic [31:0] obs_out;
  logic        obs_valid;
  logic        obs_in_ready;

  logic [1:0]  x2, y2;   logic [3:0]  o2;  logic v2, r2, ir2, ov2;
  logic [3:0]  x4, y4;   logic [7:0]  o4;  logic v4, r4, ir4, ov4;
  logic [7:0]  x8, y8;   logic [15:0] o8;  logic v8, r8, ir8, ov8;
  logic [15:0] x16, y16; logic [31:0] o16; logic v16, r16, ir16, ov16;

  always #5 clk = ~clk;

  always_comb begin
    x2  = dx[1:0];  y2  = dy[1:0];
    x4  = dx[3:0];  y4  = dy[3:0];
    x8  = dx[7:0];  y8  = dy[7:0];
    x16 = dx;       y16 = dy;
    v2  = dv && (sel == 2);  r2  = (sel == 2)  ? dr : 1'b1;
    v4  = dv && (sel == 4);  r4  = (sel == 4)  ? dr : 1'b1;
    v8  = dv && (sel == 8);  r8  = (sel == 8)  ? dr : 1'b1;
    v16 = dv && (sel == 16); r16 = (sel == 16) ? dr : 1'b1;
  end

  always_comb begin
    obs_out      = '0;
    obs_valid    = 1'b0;
    obs_in_ready = 1'b0;
    case (sel)
      2:  begin obs_out = {28'd0, o2}; obs_valid = ov2;  obs_in_ready = ir2;  end
      4:  begin obs_out = {24'd0, o4}; obs_valid = ov4;  obs_in_ready = ir4;  end
      8:  begin obs_out = {16'd0, o8}; obs_valid = ov8;  obs_in_ready = ir8;  end
      16: begin obs_out = o16;         obs_valid = ov16; obs_in_ready = ir16; end
      default: ;
    endcase
  end

  pipelined_multiplier_n #(.WIDTH(2)) u_w2 (
    .clk(clk), .rst(rst), .x(x2), .y(y2), .in_valid(v2), .in_ready(ir2),
    .out(o2), .out_valid(ov2), .out_ready(r2));
  pipelined_multiplier_n #(.WIDTH(4)) u_w4 (
    .clk(clk), .rst(rst), .x(x4), .y(y4), .in_valid(v4), .in_ready(ir4),
    .out(o4), .out_valid(ov4), .out_ready(r4));
  pipelined_multiplier_n #(.WIDTH(8)) u_w8 (
    .clk(clk), .rst(rst), .x(x8), .y(y8), .in_valid(v8), .in_ready(ir8),
    .out(o8), .out_valid(ov8), .out_ready(r8));
  pipelined_multiplier_n #(.WIDTH(16)) u_w16 (
    .clk(clk), .rst(rst), .x(x16), .y(y16), .in_valid(v16), .in_ready(ir16),
    .out(o16), .out_valid(ov16), .out_ready(r16));

  task automatic chk(input string name, input logic [63:0] got, input logic [63:0] exp);
    n_total++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %0d expected %0d", name, got, exp);
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic add_vec(input logic [15:0] x, input logic [15:0] y, input logic [31:0] exp);
    vec_t v;
    v.x = x; v.y = y; v.exp = exp;
    vecs.push_back(v);
  endtask

  task automatic do_reset(input string tag);
    dv = 1'b0; dr = 1'b1; rst = 1'b1;
    tick();
    rst = 1'b0;
    chk({tag, "_rst_out"},      64'(obs_out),      64'd0);
    chk({tag, "_rst_valid"},    64'(obs_valid),    64'd0);
    chk({tag, "_rst_in_ready"}, 64'(obs_in_ready), 64'd1);
  endtask

  // Pushes vecs through the selected instance one per cycle when accepted,
  // checking order, values, stall stability and the in_ready relation.
  task automatic stream(input int width, input bit stall, input string tag);
    logic [31:0] q[$];
    logic [31:0] held;
    logic [31:0] want;
    bit hold;
    int sent = 0, got = 0, cyc = 0, acc_cyc = -1, first_out = -1, last_out = -1;
    int n = vecs.size();
    sel = width;
    while (got < n && cyc < 400) begin
      dv = (sent < n);
      if (dv) begin dx = vecs[sent].x; dy = vecs[sent].y; end
      dr = stall ? 1'($urandom_range(0, 1)) : 1'b1;
      #1;
      chk({tag, "_in_ready"}, 64'(obs_in_ready), 64'(!obs_valid || dr));
      if (obs_valid && dr) begin
        chk({tag, "_expected_out"}, 64'(q.size() > 0), 64'd1);
        if (q.size() > 0) begin
          want = q.pop_front();
          chk({tag, "_product"}, 64'(obs_out), 64'(want));
        end
        got++;
        if (first_out < 0) first_out = cyc;
        last_out = cyc;
      end
      hold = obs_valid && !dr;
      held = obs_out;
      if (dv && obs_in_ready) begin
        q.push_back(vecs[sent].exp);
        if (sent == 0) acc_cyc = cyc;
        sent++;
      end
      tick();
      cyc++;
      if (hold) begin
        chk({tag, "_stall_out"},   64'(obs_out),   64'(held));
        chk({tag, "_stall_valid"}, 64'(obs_valid), 64'd1);
      end
    end
    dv = 1'b0;
    dr = 1'b1;
    chk({tag, "_count"}, 64'(got), 64'(n));
    if (!stall) begin
      chk({tag, "_latency"}, 64'(first_out - acc_cyc), 64'(width - 1));
      chk({tag, "_gapless"}, 64'(last_out - first_out), 64'(n - 1));
    end
  endtask

  initial begin
    // WIDTH=4: single 15*15, visible exactly 3 edges after acceptance.
    sel = 4;
    do_reset("w4");
    dx = 16'd15; dy = 16'd15; dv = 1'b1;
    tick();
    dv = 1'b0;
    chk("w4_e1_valid", 64'(obs_valid), 64'd0);
    tick();
    chk("w4_e2_valid", 64'(obs_valid), 64'd0);
    tick();
    chk("w4_e3_valid", 64'(obs_valid), 64'd1);
    chk("w4_e3_out",   64'(obs_out),   64'd225);
    tick();
    chk("w4_e4_valid", 64'(obs_valid), 64'd0);

    // WIDTH=4: valid pattern 1,0,1 keeps its bubble.
    do_reset("w4b");
    dx = 16'd3; dy = 16'd5; dv = 1'b1;
    tick();
    dv = 1'b0;
    tick();
    dx = 16'd7; dy = 16'd9; dv = 1'b1;
    tick();
    dv = 1'b0;
    chk("w4b_v0", 64'(obs_valid), 64'd1);
    chk("w4b_o0", 64'(obs_out),   64'd15);
    tick();
    chk("w4b_v1_bubble", 64'(obs_valid), 64'd0);
    tick();
    chk("w4b_v2", 64'(obs_valid), 64'd1);
    chk("w4b_o2", 64'(obs_out),   64'd63);
    tick();
    chk("w4b_v3", 64'(obs_valid), 64'd0);

    // WIDTH=8: back-to-back directed pairs.
    sel = 8;
    do_reset("w8");
    vecs.delete();
    add_vec(16'd255, 16'd255, 32'd65025);
    add_vec(16'd0,   16'd200, 32'd0);
    add_vec(16'd1,   16'd1,   32'd1);
    add_vec(16'd128, 16'd2,   32'd256);
    stream(8, 1'b0, "w8_b2b");

    // WIDTH=8: random stream with random backpressure.
    do_reset("w8r");
    vecs.delete();
    for (int i = 0; i < 10; i++) begin
      logic [15:0] rx, ry;
      rx = 16'($urandom_range(0, 255));
      ry = 16'($urandom_range(0, 255));
      add_vec(rx, ry, 32'(rx) * 32'(ry));
    end
    stream(8, 1'b1, "w8_rand");

    // WIDTH=8: reset with five products in flight.
    do_reset("w8x");
    for (int i = 0; i < 5; i++) begin
      dx = 16'(i + 10); dy = 16'd3; dv = 1'b1;
      tick();
      chk("w8x_inflight_valid", 64'(obs_valid), 64'd0);
    end
    dv = 1'b0;
    rst = 1'b1;
    tick();
    rst = 1'b0;
    chk("w8x_post_rst_out",   64'(obs_out),   64'd0);
    chk("w8x_post_rst_valid", 64'(obs_valid), 64'd0);
    for (int i = 0; i < 10; i++) begin
      tick();
      chk("w8x_no_stale", 64'(obs_valid), 64'd0);
    end
    vecs.delete();
    add_vec(16'd12, 16'd11, 32'd132);
    stream(8, 1'b0, "w8x_new");

    // WIDTH=16: corner table.
    sel = 16;
    do_reset("w16");
    vecs.delete();
    add_vec(16'd0,     16'd12345, 32'd0);
    add_vec(16'd54321, 16'd0,     32'd0);
    add_vec(16'd65535, 16'd65535, 32'd4294836225);
    add_vec(16'd65535, 16'd1,     32'd65535);
    add_vec(16'd1234,  16'd5678,  32'd7006652);
    stream(16, 1'b0, "w16");

    // WIDTH=2: exhaustive.
    sel = 2;
    do_reset("w2");
    vecs.delete();
    for (int i = 0; i < 4; i++)
      for (int j = 0; j < 4; j++)
        add_vec(16'(i), 16'(j), 32'(i * j));
    stream(2, 1'b0, "w2");

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not complete, %0d/%0d checks passed", n_pass, n_total);
    $fatal(1);
  end

endmodule
